// File: rtl/bit_serial_tx.sv
// bit_serial_tx: MSB-first NRZ serializer with a latched, clamped bit period.
// Define IDLE_TOGGLE_EN to make the idle line toggle every bit cell instead of holding 1.
module bit_serial_tx #(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk_200M,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                signal,
    output logic                bit_strobe,
    output logic                busy
);
    localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [PERIOD_W-1:0] cnt, p;
    logic [DATA_W-1:0]   shreg;
    logic                boundary, last, accept;
    assign boundary = cnt == p - PERIOD_W'(1);
    assign last     = state == SHIFT && idx == IDX_W'(DATA_W - 1);
    assign tx_ready = boundary && (state == IDLE || last);
    assign accept   = tx_valid && tx_ready;
    // shreg keeps the bit currently on the line in its MSB
    always_ff @(posedge clk_200M)
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            p          <= PERIOD_W'(2);
            shreg      <= '0;
            signal     <= 1'b1;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt        <= boundary ? '0 : cnt + PERIOD_W'(1);
            bit_strobe <= boundary;
            if (boundary) begin
                p <= bit_period < PERIOD_W'(2) ? PERIOD_W'(2) : bit_period;
                if (accept) begin
                    shreg  <= tx_data;
                    signal <= tx_data[DATA_W-1];
                    idx    <= '0;
                    state  <= SHIFT;
                    busy   <= 1'b1;
                end else if (state == SHIFT && !last) begin
                    shreg  <= shreg << 1;
                    signal <= shreg[DATA_W-2];
                    idx    <= idx + IDX_W'(1);
                end else if (state == SHIFT) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    signal <= 1'b1;
                end else begin
`ifdef IDLE_TOGGLE_EN
                    signal <= ~signal;
`else
                    signal <= 1'b1;
`endif
                end
            end
        end
endmodule

// File: doc/bit_serial_tx.md
BIT_SERIAL_TX -- requirements
Module: bit_serial_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning bits per transmitted word.
REQ-002 The block SHALL have parameter PERIOD_W, default 16, meaning the width of the bit-period field and bit timer.
REQ-003 The block SHALL have port clk_200M  input  1  base clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port bit_period  input  PERIOD_W  clk_200M cycles per transmitted bit.
REQ-006 The block SHALL have port tx_data  input  DATA_W  word to send, MSB first.
REQ-007 The block SHALL have port tx_valid  input  1  tx_data valid; held until accepted.
REQ-008 The block SHALL have port tx_ready  output  1  combinational; the word is accepted on a cycle where tx_valid && tx_ready.
REQ-009 The block SHALL have port signal  output  1  registered serial NRZ line.
REQ-010 The block SHALL have port bit_strobe  output  1  registered one-cycle pulse in the first cycle of each new bit cell.
REQ-011 The block SHALL have port busy  output  1  registered; high while a data word is being shifted.

Function
REQ-012 A free-running bit timer cnt (PERIOD_W bits) SHALL count 0..P-1 in every state and wrap to 0; boundary = (cnt == P-1).
REQ-013 P SHALL be latched from bit_period at every boundary, so a mid-bit change takes effect from the next bit cell.
REQ-014 A bit_period value of 0 or 1 SHALL be clamped to 2 when latched.
REQ-015 The FSM SHALL have states IDLE and SHIFT, plus a bit index idx of 0..DATA_W-1.
REQ-016 tx_ready SHALL equal boundary && (state==IDLE || (state==SHIFT && idx==DATA_W-1)).
REQ-017 On accept, the block SHALL register tx_data into the shift register, drive signal to tx_data[DATA_W-1] in the next cycle, and set idx=0, state=SHIFT, busy=1.
REQ-018 In SHIFT, at a boundary with idx<DATA_W-1, the next bit SHALL be driven and idx incremented.
REQ-019 At the last-bit boundary with no accept, the block SHALL go to IDLE with busy=0; with an accept, it SHALL load the new word back-to-back with no gap cell.
REQ-020 Each data bit SHALL occupy exactly P cycles on signal, and first-bit latency from accept SHALL be 1 cycle.
REQ-021 bit_strobe SHALL pulse in the cycle after every boundary, in both IDLE and SHIFT.
REQ-022 In IDLE at a boundary without accept, signal SHALL follow the idle rule in REQ-027/REQ-028.
REQ-023 If tx_valid drops before acceptance, no word SHALL be sent; tx_data changes while not accepted SHALL be ignored.
REQ-024 Counter wrap SHALL be modulo 2^PERIOD_W with no overflow state; bit_period=2^PERIOD_W-1 SHALL be legal.

Reset
REQ-025 While rst_n==0 at a clock edge, the block SHALL set state=IDLE, idx=0, cnt=0, P=2, signal=1, bit_strobe=0, busy=0, and clear the shift register; tx_ready SHALL therefore be 0 in the first cycle after reset.
REQ-026 A reset asserted mid-word SHALL abort the word, with no partial-word completion after release.

Configuration
REQ-027 With macro IDLE_TOGGLE_EN defined, signal SHALL invert at every IDLE boundary, giving a 1010 pattern with period 2P that keeps downstream clock recovery locked.
REQ-028 Without IDLE_TOGGLE_EN, signal SHALL hold 1 throughout IDLE, and the inversion logic SHALL be absent.

Verification
REQ-029 Reset test: rst_n=0 for 3 cycles, then 1 -> signal=1, busy=0, bit_strobe=0, tx_ready=0 in the first cycle after release; first bit_strobe after exactly 2 cycles (P=2), then every bit_period cycles.
REQ-030 Single-word test: bit_period=4, tx_data=8'hA5, one accept -> signal shows 1,0,1,0,0,1,0,1 for 4 cycles each starting 1 cycle after accept; busy falls after 32 cycles.
REQ-031 Back-to-back test: bit_period=3, words 8'hFF then 8'h00 with tx_valid held -> 24 cycles of 1 immediately followed by 24 cycles of 0, with tx_ready pulsing exactly twice.
REQ-032 Clamp and mid-bit change test: bit_period=1 -> cells of 2 cycles; change bit_period from 5 to 7 mid-cell -> current cell stays 5 cycles and the next cell is 7 cycles.
REQ-033 Idle test, IDLE_TOGGLE_EN defined, bit_period=10, no valid -> signal toggles every 10 cycles; with the macro undefined -> signal constant 1.
REQ-034 Abort test: reset asserted during bit 3 of 8'h3C -> after release signal=1 and idle behaviour, with no remaining bits emitted.
